// File: rtl/cs161_control_fsm_pkg.sv
// Shared encodings for the cs161 multi-cycle control unit: opcodes, functs,
// ALU control codes, FSM state encoding, instruction classes and error codes.
package cs161_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  // CLS_IMM covers addi/slti: both are reg-immediate ALU ops with writeback
  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_IMM, CLS_LW, CLS_SW, CLS_BEQ
  } cls_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_IMEM    = 2'd2,
    ERR_DMEM    = 2'd3
  } err_e;

  typedef struct packed {
    cls_e       cls;
    logic [3:0] alu_op;
    logic       legal;
  } dec_t;

endpackage

// File: rtl/cs161_control_fsm_if.sv
// Control-unit <-> datapath/memory bundle. master = control FSM side.
interface cs161_control_fsm_if #(parameter int CNT_W = 32);
  logic [5:0]       instr_op;
  logic [5:0]       funct;
  logic             imem_ready;
  logic             dmem_ready;
  logic             fetch_req;
  logic             ir_write;
  logic             pc_write;
  logic             reg_dst;
  logic             branch;
  logic             mem_read;
  logic             mem_to_reg;
  logic             mem_write;
  logic             alu_src;
  logic             reg_write;
  logic [3:0]       alu_op;
  logic [2:0]       state_dbg;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr_op, funct, imem_ready, dmem_ready,
    output fetch_req, ir_write, pc_write, reg_dst, branch, mem_read,
           mem_to_reg, mem_write, alu_src, reg_write, alu_op,
           state_dbg, err_code, retired
  );

  modport slave (
    output instr_op, funct, imem_ready, dmem_ready,
    input  fetch_req, ir_write, pc_write, reg_dst, branch, mem_read,
           mem_to_reg, mem_write, alu_src, reg_write, alu_op,
           state_dbg, err_code, retired
  );
endinterface

// File: rtl/cs161_control_fsm_decode.sv
// Combinational instruction decode: opcode/funct -> {class, ALU code, legal}.
module cs161_ctrl_decode
  import cs161_pkg::*;
(
  input  logic [5:0] instr_op,
  input  logic [5:0] funct,
  output dec_t       dec
);

  // funct is only meaningful for R-type; I-types ignore it entirely
  always_comb begin
    dec = '{cls: CLS_NONE, alu_op: ALU_AND, legal: 1'b0};
    case (instr_op)
      OP_RTYPE: begin
        dec.cls   = CLS_R;
        dec.legal = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_NOR:  dec.alu_op = ALU_NOR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: dec.legal  = 1'b0;
        endcase
      end
      OP_LW:   dec = '{cls: CLS_LW,  alu_op: ALU_ADD, legal: 1'b1};
      OP_SW:   dec = '{cls: CLS_SW,  alu_op: ALU_ADD, legal: 1'b1};
      OP_BEQ:  dec = '{cls: CLS_BEQ, alu_op: ALU_SUB, legal: 1'b1};
      OP_ADDI: dec = '{cls: CLS_IMM, alu_op: ALU_ADD, legal: 1'b1};
      OP_SLTI: dec = '{cls: CLS_IMM, alu_op: ALU_SLT, legal: 1'b1};
      default: ;
    endcase
  end

endmodule

// File: rtl/cs161_control_fsm.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with ready handshakes,
// wait-counter timeouts, sticky TRAP and a retired-instruction counter.
module cs161_control_fsm
  import cs161_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  cs161_control_fsm_if.master bus
);

  localparam int         WC_W  = 16;
  localparam logic [WC_W-1:0] TMO_W = WC_W'(TIMEOUT);

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [3:0]       alu_q, alu_d;
  err_e             err_q, err_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  dec_t             dec;

  logic fetch_req, ir_write, pc_write, reg_dst, branch, mem_read;
  logic mem_to_reg, mem_write, alu_src, reg_write;
  logic [3:0] alu_op;

  cs161_ctrl_decode u_dec (
    .instr_op (bus.instr_op),
    .funct    (bus.funct),
    .dec      (dec)
  );

  // state, latched decode, error, wait counter and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= CLS_NONE;
      alu_q   <= '0;
      err_q   <= ERR_NONE;
      wcnt_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      alu_q   <= alu_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      ret_q   <= ret_d;
    end
  end

  // next state; wait counter defaults to 0 so every state change clears it
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    alu_d   = alu_q;
    err_d   = err_q;
    wcnt_d  = '0;
    ret_d   = ret_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) begin
          state_d = S_DECODE;
        end else if (wcnt_q == TMO_W) begin
          state_d = S_TRAP;
          err_d   = ERR_IMEM;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      S_DECODE: begin
        cls_d = dec.cls;
        alu_d = dec.alu_op;
        if (dec.legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          err_d   = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (cls_q)
          CLS_LW, CLS_SW: state_d = S_MEM;
          CLS_BEQ: begin
            state_d = S_FETCH;
            ret_d   = ret_q + CNT_W'(1);
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (bus.dmem_ready) begin
          if (cls_q == CLS_SW) begin
            state_d = S_FETCH;
            ret_d   = ret_q + CNT_W'(1);
          end else begin
            state_d = S_WB;
          end
        end else if (wcnt_q == TMO_W) begin
          state_d = S_TRAP;
          err_d   = ERR_DMEM;
        end else begin
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        ret_d   = ret_q + CNT_W'(1);
      end
      S_TRAP: ;
      default: state_d = S_FETCH;
    endcase
  end

  // control decode from state + latched class; all forced low while in reset
  always_comb begin
    fetch_req  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_dst    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = '0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          fetch_req = 1'b1;
          ir_write  = bus.imem_ready;
          pc_write  = bus.imem_ready;
        end
        S_EXEC: begin
          alu_op = alu_q;
          case (cls_q)
            CLS_R:                  reg_dst = 1'b1;
            CLS_IMM, CLS_LW, CLS_SW: alu_src = 1'b1;
            CLS_BEQ: begin
              branch   = 1'b1;
              pc_write = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          alu_src   = 1'b1;
          alu_op    = ALU_ADD;
          mem_read  = (cls_q == CLS_LW);
          mem_write = (cls_q == CLS_SW);
        end
        S_WB: begin
          reg_write = 1'b1;
          case (cls_q)
            CLS_LW: mem_to_reg = 1'b1;
            CLS_R:  reg_dst    = 1'b1;
            CLS_IMM: begin
              alu_src = 1'b1;
              alu_op  = alu_q;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.fetch_req  = fetch_req;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.branch     = branch;
  assign bus.mem_read   = mem_read;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.mem_write  = mem_write;
  assign bus.alu_src    = alu_src;
  assign bus.reg_write  = reg_write;
  assign bus.alu_op     = alu_op;
  assign bus.state_dbg  = rst ? 3'd0 : state_q;
  assign bus.err_code   = rst ? 2'd0 : err_q;
  assign bus.retired    = rst ? '0 : ret_q;

endmodule

// File: tb/tb_cs161_control_fsm.sv
// Self-checking bench for cs161_control_fsm: directed scenarios plus a random
// instruction stream checked cycle-by-cycle against a rule-level model.
module tb_cs161_control_fsm;

  localparam int TMO   = 4;
  localparam int CNT_W = 32;
  localparam int K_R = 0, K_IMM = 1, K_LW = 2, K_SW = 3, K_BEQ = 4;

  typedef struct packed {
    logic fr, irw, pcw, rd, br, mr, m2r, mw, as, rw;
    logic [3:0] alu;
    logic [2:0] st;
    logic [1:0] err;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         any_fn;
    int         kind;
    logic [3:0] alu;
  } ins_t;

  logic clk, rst;
  int errors, checks;
  logic [CNT_W-1:0] exp_ret;
  ins_t tbl[11];

  cs161_control_fsm_if #(.CNT_W(CNT_W)) bus ();

  cs161_control_fsm #(.TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  function automatic obs_t sample();
    obs_t o;
    o.fr  = bus.fetch_req;  o.irw = bus.ir_write;   o.pcw = bus.pc_write;
    o.rd  = bus.reg_dst;    o.br  = bus.branch;     o.mr  = bus.mem_read;
    o.m2r = bus.mem_to_reg; o.mw  = bus.mem_write;  o.as  = bus.alu_src;
    o.rw  = bus.reg_write;  o.alu = bus.alu_op;     o.st  = bus.state_dbg;
    o.err = bus.err_code;
    return o;
  endfunction

  function automatic void lookup(input logic [5:0] op, input logic [5:0] fn,
                                 output bit legal, output int kind, output logic [3:0] alu);
    legal = 1'b0; kind = -1; alu = '0;
    foreach (tbl[i])
      if (tbl[i].op == op && (tbl[i].any_fn || tbl[i].fn == fn)) begin
        legal = 1'b1; kind = tbl[i].kind; alu = tbl[i].alu;
      end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = '0;
  endtask

  // Walks one legal instruction from FETCH back to FETCH, checking every cycle.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input int iw, input int dw);
    bit legal; int kind; logic [3:0] alu; obs_t e, o;
    lookup(op, fn, legal, kind, alu);
    bus.instr_op = op;
    bus.funct    = fn;
    for (int i = 0; i <= iw; i++) begin
      bus.imem_ready = (i == iw);
      bus.dmem_ready = 1'($urandom);
      #1;
      e = '0; e.fr = 1'b1; e.irw = (i == iw); e.pcw = (i == iw); e.st = 3'd0;
      o = sample(); checks++;
      if (o !== e || bus.retired !== exp_ret) begin
        errors++;
        $display("FAIL %s fetch[%0d]: got=%h exp=%h retired=%0d exp=%0d", tag, i, o, e, bus.retired, exp_ret);
      end
      @(negedge clk);
    end
    bus.imem_ready = 1'($urandom);
    bus.dmem_ready = 1'($urandom);
    #1;
    e = '0; e.st = 3'd1;
    o = sample(); checks++;
    if (o !== e || bus.retired !== exp_ret) begin
      errors++;
      $display("FAIL %s decode: got=%h exp=%h retired=%0d exp=%0d", tag, o, e, bus.retired, exp_ret);
    end
    @(negedge clk);
    bus.imem_ready = 1'($urandom);
    bus.dmem_ready = 1'($urandom);
    #1;
    e = '0; e.st = 3'd2; e.alu = alu;
    if (kind == K_R) e.rd = 1'b1;
    else if (kind == K_BEQ) begin e.br = 1'b1; e.pcw = 1'b1; end
    else e.as = 1'b1;
    o = sample(); checks++;
    if (o !== e || bus.retired !== exp_ret) begin
      errors++;
      $display("FAIL %s exec: got=%h exp=%h retired=%0d exp=%0d", tag, o, e, bus.retired, exp_ret);
    end
    @(negedge clk);
    if (kind == K_LW || kind == K_SW) begin
      for (int j = 0; j <= dw; j++) begin
        bus.dmem_ready = (j == dw);
        bus.imem_ready = 1'($urandom);
        #1;
        e = '0; e.st = 3'd3; e.as = 1'b1; e.alu = 4'b0010;
        e.mr = (kind == K_LW); e.mw = (kind == K_SW);
        o = sample(); checks++;
        if (o !== e || bus.retired !== exp_ret) begin
          errors++;
          $display("FAIL %s mem[%0d]: got=%h exp=%h retired=%0d exp=%0d", tag, j, o, e, bus.retired, exp_ret);
        end
        @(negedge clk);
      end
    end
    if (kind == K_R || kind == K_IMM || kind == K_LW) begin
      bus.imem_ready = 1'($urandom);
      bus.dmem_ready = 1'($urandom);
      #1;
      e = '0; e.st = 3'd4; e.rw = 1'b1;
      if (kind == K_LW) e.m2r = 1'b1;
      if (kind == K_R) e.rd = 1'b1;
      if (kind == K_IMM) begin e.as = 1'b1; e.alu = alu; end
      o = sample(); checks++;
      if (o !== e || bus.retired !== exp_ret) begin
        errors++;
        $display("FAIL %s wb: got=%h exp=%h retired=%0d exp=%0d", tag, o, e, bus.retired, exp_ret);
      end
      @(negedge clk);
    end
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    exp_ret = exp_ret + 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    rst = 1'b1;
    bus.instr_op = '0; bus.funct = '0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    o = sample(); checks++;
    if (o !== '0 || bus.retired !== '0) begin
      errors++;
      $display("FAIL reset_hold: got=%h exp=0 retired=%0d exp=0", o, bus.retired);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    e = '0; e.fr = 1'b1;
    o = sample(); checks++;
    if (o !== e || bus.retired !== '0) begin
      errors++;
      $display("FAIL reset_release: got=%h exp=%h retired=%0d", o, e, bus.retired);
    end
  endtask

  // add then beq: checks the retire count and the return to FETCH with no WB
  task automatic test_add_beq();
    obs_t e, o;
    do_reset();
    run_instr("add", 6'h00, 6'h20, 0, 0);
    run_instr("beq", 6'h04, 6'($urandom), 1, 0);
    #1;
    e = '0; e.fr = 1'b1;
    o = sample(); checks++;
    if (o !== e || bus.retired !== 32'd2) begin
      errors++;
      $display("FAIL beq_next: got=%h exp=%h retired=%0d exp=2", o, e, bus.retired);
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    run_instr("lw_wait3", 6'h23, 6'($urandom), 0, 3);
    run_instr("sw_wait0", 6'h2B, 6'($urandom), 2, 0);
  endtask

  task automatic test_illegal();
    obs_t e, o; bit legal; int kind; logic [3:0] alu; logic [5:0] op, fn;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      if (k == 0) begin
        op = 6'h3F; fn = 6'($urandom);
      end else begin
        run_instr("pre_illegal", 6'h08, 6'($urandom), 0, 0);
        op = 6'h00; fn = 6'($urandom);
        lookup(op, fn, legal, kind, alu);
        if (legal) fn = 6'h21;
      end
      bus.instr_op = op; bus.funct = fn; bus.imem_ready = 1'b1;
      @(negedge clk);
      bus.imem_ready = 1'b0;
      #1;
      e = '0; e.st = 3'd1;
      o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL illegal_decode[%0d]: got=%h exp=%h", k, o, e);
      end
      @(negedge clk);
      for (int c = 0; c < 20; c++) begin
        bus.imem_ready = 1'($urandom); bus.dmem_ready = 1'($urandom);
        #1;
        e = '0; e.st = 3'd7; e.err = 2'd1;
        o = sample(); checks++;
        if (o !== e || bus.retired !== exp_ret) begin
          errors++;
          $display("FAIL illegal_trap[%0d] c%0d: got=%h exp=%h retired=%0d exp=%0d", k, c, o, e, bus.retired, exp_ret);
        end
        @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; bus.imem_ready = 1'b0;
      #1;
      e = '0; e.fr = 1'b1;
      o = sample(); checks++;
      if (o !== e || bus.retired !== '0) begin
        errors++;
        $display("FAIL trap_reset[%0d]: got=%h exp=%h retired=%0d exp=0", k, o, e, bus.retired);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    // imem never ready: TIMEOUT+1 FETCH cycles then TRAP err 2
    do_reset();
    for (int i = 0; i <= TMO; i++) begin
      #1;
      e = '0; e.fr = 1'b1;
      o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL imem_wait[%0d]: got=%h exp=%h", i, o, e);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 3; c++) begin
      bus.imem_ready = 1'($urandom);
      #1;
      e = '0; e.st = 3'd7; e.err = 2'd2;
      o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL imem_trap c%0d: got=%h exp=%h", c, o, e);
      end
      @(negedge clk);
    end
    // ready in the same cycle the counter hits TIMEOUT wins
    do_reset();
    run_instr("imem_edge", 6'h0A, 6'($urandom), TMO, 0);
    run_instr("dmem_edge", 6'h23, 6'($urandom), 0, TMO);
    // dmem never ready: TRAP err 3
    do_reset();
    bus.instr_op = 6'h23; bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    for (int j = 0; j <= TMO; j++) begin
      #1;
      e = '0; e.st = 3'd3; e.as = 1'b1; e.alu = 4'b0010; e.mr = 1'b1;
      o = sample(); checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL dmem_wait[%0d]: got=%h exp=%h", j, o, e);
      end
      @(negedge clk);
    end
    #1;
    e = '0; e.st = 3'd7; e.err = 2'd3;
    o = sample(); checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL dmem_trap: got=%h exp=%h", o, e);
    end
  endtask

  task automatic test_sw_reset();
    obs_t e, o;
    do_reset();
    run_instr("pre_sw", 6'h00, 6'h25, 0, 0);
    bus.instr_op = 6'h2B; bus.imem_ready = 1'b1;
    @(negedge clk);
    bus.imem_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    e = '0; e.st = 3'd3; e.as = 1'b1; e.alu = 4'b0010; e.mw = 1'b1;
    o = sample(); checks++;
    if (o !== e || bus.retired !== 32'd1) begin
      errors++;
      $display("FAIL sw_mem: got=%h exp=%h retired=%0d exp=1", o, e, bus.retired);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    o = sample(); checks++;
    if (o !== '0 || bus.retired !== '0) begin
      errors++;
      $display("FAIL sw_reset_hold: got=%h exp=0 retired=%0d exp=0", o, bus.retired);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    e = '0; e.fr = 1'b1;
    o = sample(); checks++;
    if (o !== e || bus.retired !== '0) begin
      errors++;
      $display("FAIL sw_reset_fetch: got=%h exp=%h retired=%0d exp=0", o, e, bus.retired);
    end
  endtask

  task automatic test_random();
    int idx; logic [5:0] fn; obs_t e, o;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 10);
      fn  = tbl[idx].any_fn ? 6'($urandom) : tbl[idx].fn;
      run_instr($sformatf("rand%0d", n), tbl[idx].op, fn, $urandom_range(0, TMO), $urandom_range(0, TMO));
    end
    #1;
    e = '0; e.fr = 1'b1;
    o = sample(); checks++;
    if (o !== e || bus.retired !== 32'd60) begin
      errors++;
      $display("FAIL rand_total: got=%h exp=%h retired=%0d exp=60", o, e, bus.retired);
    end
  endtask

  initial begin
    errors = 0; checks = 0; exp_ret = '0; rst = 1'b1;
    tbl[0]  = '{6'h00, 6'h20, 1'b0, K_R,   4'b0010};
    tbl[1]  = '{6'h00, 6'h22, 1'b0, K_R,   4'b0110};
    tbl[2]  = '{6'h00, 6'h24, 1'b0, K_R,   4'b0000};
    tbl[3]  = '{6'h00, 6'h25, 1'b0, K_R,   4'b0001};
    tbl[4]  = '{6'h00, 6'h27, 1'b0, K_R,   4'b1100};
    tbl[5]  = '{6'h00, 6'h2A, 1'b0, K_R,   4'b0111};
    tbl[6]  = '{6'h23, 6'h00, 1'b1, K_LW,  4'b0010};
    tbl[7]  = '{6'h2B, 6'h00, 1'b1, K_SW,  4'b0010};
    tbl[8]  = '{6'h04, 6'h00, 1'b1, K_BEQ, 4'b0110};
    tbl[9]  = '{6'h08, 6'h00, 1'b1, K_IMM, 4'b0010};
    tbl[10] = '{6'h0A, 6'h00, 1'b1, K_IMM, 4'b0111};
    test_reset();
    test_add_beq();
    test_lw_wait();
    test_illegal();
    test_timeout();
    test_sw_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cs161_control_fsm.md
Name: cs161_control_fsm

Overview:
- Multi-cycle control unit that drives cs161_datapath.
- Consumes the datapath's decoded instr_op/funct fields. Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives every datapath control input.
- Handshakes with instruction and data memory through ready signals. Counts retired instructions. Traps on illegal opcodes or memory timeouts.

Parameters:
- TIMEOUT, 255, maximum cycles spent waiting on a ready signal before trapping; legal range 1..65535.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-high.
- instr_op  in  6  opcode field from the datapath.
- funct  in  6  function field from the datapath.
- imem_ready  in  1  instruction memory has valid data this cycle.
- dmem_ready  in  1  data memory access completes this cycle.
- fetch_req  out  1  request an instruction fetch.
- ir_write  out  1  latch the instruction register.
- pc_write  out  1  advance the PC (PC+4, or the branch target when branch is high).
- reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write  out  1 each  datapath controls.
- alu_op  out  4  ALU control code.
- state_dbg  out  3  current state encoding.
- err_code  out  2  0 none, 1 illegal instruction, 2 imem timeout, 3 dmem timeout.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset: state=FETCH, every output 0, retired=0, err_code=0, wait counter=0. Reset takes effect from any state, including TRAP and mid-handshake.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Outputs are Moore-style, decoded from the state register plus the class/ALU code latched in DECODE. Every control not listed for a state is 0.
- FETCH:
  - fetch_req=1.
  - On imem_ready: ir_write=1 and pc_write=1 in that same cycle; go to DECODE.
- DECODE: latch the instruction class and ALU code from instr_op/funct; 1 cycle.
  - Legal instruction: go to EXEC.
  - Illegal instruction: go to TRAP with err_code=1.
- Legal instructions:
  - R-type (op 0x00) with funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt. Any other funct is illegal.
  - I-type: lw 0x23, sw 0x2B, beq 0x04, addi 0x08, slti 0x0A.
- alu_op codes: and 0000, or 0001, add 0010, sub 0110, slt 0111, nor 1100.
  - lw, sw and addi use add.
  - beq uses sub.
  - slti uses slt.
- EXEC (1 cycle): alu_op valid in every instruction class.
  - R-type: reg_dst=1; go to WB.
  - addi/slti: alu_src=1; go to WB.
  - lw/sw: alu_src=1; go to MEM.
  - beq: branch=1 and pc_write=1; go to FETCH; the instruction retires.
- MEM: alu_src=1 and alu_op=add held throughout.
  - lw: mem_read=1 until dmem_ready; then go to WB.
  - sw: mem_write=1 until dmem_ready; then retire and go to FETCH.
- WB (1 cycle): reg_write=1; go to FETCH; retire.
  - lw: mem_to_reg=1.
  - R-type: reg_dst=1.
  - addi/slti: alu_src=1, alu_op held.
- retired increments by 1 on the cycle that leaves WB, leaves EXEC for beq, or leaves MEM for sw. It wraps modulo 2^CNT_W.
- Wait counter:
  - Clears on entry to FETCH or MEM, and increments on each cycle in FETCH or MEM without ready.
  - If the counter reaches TIMEOUT while ready is still low, go to TRAP with err_code 2 (FETCH) or 3 (MEM).
  - Ready arriving in the same cycle the counter equals TIMEOUT wins: no trap.
- TRAP: sticky until rst. All controls are 0, state_dbg=7, err_code holds, retired holds.
- pc_write and ir_write are never both asserted outside FETCH. reg_write and mem_write are never both high.

Decomposition:
- Shared package cs161_pkg holds:
  - Opcode and funct constants.
  - ALU control codes.
  - State encoding.
  - err_code values.
- One sub-module, cs161_ctrl_decode: combinational map from instr_op/funct to {class, alu_op, legal}. It is instantiated once and its result is registered in DECODE.

Test Plan:
- add (op 0, funct 0x20), imem_ready high: state sequence 0,1,2,4,0. EXEC shows alu_op=0010, reg_dst=1. WB shows reg_write=1. retired goes 0 to 1.
- lw (op 0x23), dmem_ready held low 3 cycles: mem_read=1 for 4 MEM cycles. WB shows mem_to_reg=1, reg_write=1. retired increments once.
- beq (op 0x04): EXEC shows branch=1, pc_write=1, alu_op=0110. Next state is FETCH, with no WB and no reg_write. retired increments.
- op 0x3F: DECODE goes to TRAP next cycle, err_code=1, state_dbg=7. Outputs stay 0 for 20 cycles. rst=1 for 1 cycle returns state 0, err_code 0, retired 0.
- TIMEOUT=4, imem_ready held low: TRAP after the counter reaches 4 with err_code=2. Repeating with imem_ready rising exactly when the counter reaches 4 gives DECODE instead.
- sw (op 0x2B) with rst asserted during MEM while mem_write=1: next cycle all outputs are 0, state is FETCH, and retired is 0.
